// File: rtl/updown_counter_ctrl.sv
// Sequencing controller for the up/down counter: owns count, run/pause/idle state,
// direction, next-value select, terminal-count pulse and lap counter.
module updown_counter_ctrl #(
  parameter int WIDTH = 5,
  parameter int MAXV  = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir_in,
  input  logic             auto_rev,
  output logic [WIDTH-1:0] count,
  output logic             mode,
  output logic [1:0]       sel,
  output logic             tc,
  output logic [3:0]       laps,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_STEP = 2'b01;
  localparam logic [1:0] SEL_TERM = 2'b10;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAXV);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             term;
  logic             run_step;
  logic [WIDTH-1:0] load_sat;
  logic [WIDTH-1:0] count_nxt;
  logic             mode_nxt;

  assign term     = (!mode && count == MAX_V) || (mode && count == '0);
  assign sel      = (state != ST_RUN) ? SEL_HOLD : (term ? SEL_TERM : SEL_STEP);
  assign busy     = (state == ST_RUN) || (state == ST_PAUSE);
  assign load_sat = (load_val > MAX_V) ? MAX_V : load_val;
  // stop in RUN suppresses the update at the same edge
  assign run_step = (state == ST_RUN) && !stop;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (stop) state_nxt = ST_PAUSE;
      ST_PAUSE: begin
        if (stop)       state_nxt = ST_IDLE;
        else if (start) state_nxt = ST_RUN;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    mode_nxt  = mode;
    if (run_step) begin
      if (!term) begin
        count_nxt = mode ? (count - ONE) : (count + ONE);
      end else if (auto_rev) begin
        mode_nxt  = !mode;
        count_nxt = mode ? ONE : (MAX_V - ONE);
      end else begin
        count_nxt = mode ? MAX_V : '0;
      end
    end else if (load && (state == ST_IDLE || state == ST_PAUSE)) begin
      count_nxt = load_sat;
    end
    if (state == ST_IDLE && start) mode_nxt = dir_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      mode  <= 1'b0;
      tc    <= 1'b0;
      laps  <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      mode  <= mode_nxt;
      tc    <= run_step && term;
      if (state == ST_IDLE && start) laps <= '0;
      else if (run_step && term && laps != 4'hF) laps <= laps + 4'd1;
    end
  end

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Directed self-checking bench for updown_counter_ctrl (WIDTH=5, MAXV=30).
module tb_updown_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, load, dir_in, auto_rev;
  logic [4:0] load_val;
  logic [4:0] count;
  logic       mode;
  logic [1:0] sel;
  logic       tc;
  logic [3:0] laps;
  logic       busy;

  int checks = 0;
  int errors = 0;

  updown_counter_ctrl #(.WIDTH(5), .MAXV(30)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .dir_in(dir_in), .auto_rev(auto_rev),
    .count(count), .mode(mode), .sel(sel), .tc(tc), .laps(laps), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       st, sp, ld;
    logic [4:0] lv;
    logic       dr, ar;
    logic [4:0] c;
    logic       m;
    logic [1:0] s;
    logic       t;
    logic [3:0] l;
    logic       b;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic st, logic sp, logic ld, logic [4:0] lv, logic dr,
                              logic ar, logic [4:0] c, logic m, logic [1:0] s,
                              logic t, logic [3:0] l, logic b);
    vec_t v;
    v = '{st, sp, ld, lv, dr, ar, c, m, s, t, l, b};
    return v;
  endfunction

  task automatic check(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_all(string name, logic [4:0] c, logic m, logic [1:0] s,
                           logic t, logic [3:0] l, logic b);
    checks++;
    if ({count, mode, sel, tc, laps, busy} !== {c, m, s, t, l, b}) begin
      errors++;
      $display("FAIL %s got count=%0d mode=%0d sel=%0d tc=%0d laps=%0d busy=%0d exp count=%0d mode=%0d sel=%0d tc=%0d laps=%0d busy=%0d",
               name, count, mode, sel, tc, laps, busy, c, m, s, t, l, b);
    end
  endtask

  task automatic drive(logic st, logic sp, logic ld, logic [4:0] lv, logic dr, logic ar);
    @(negedge clk);
    start = st; stop = sp; load = ld; load_val = lv; dir_in = dr; auto_rev = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0; stop = 0; load = 0; load_val = '0; dir_in = 0; auto_rev = 0;
    rst_n = 1'b0;
    #1;
    check_all("reset_state", 5'd0, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; stop = 0; load = 0; load_val = '0; dir_in = 0; auto_rev = 0;

    //                st sp ld  lv    dr ar   count m  sel    tc laps busy
    vecs[0]  = mk(0, 0, 1, 5'd31, 0, 0, 5'd30, 0, 2'b00, 0, 4'd0, 0);
    vecs[1]  = mk(1, 0, 1, 5'd28, 0, 1, 5'd28, 0, 2'b01, 0, 4'd0, 1);
    vecs[2]  = mk(0, 0, 0, 5'd0,  0, 1, 5'd29, 0, 2'b01, 0, 4'd0, 1);
    vecs[3]  = mk(0, 0, 0, 5'd0,  0, 1, 5'd30, 0, 2'b10, 0, 4'd0, 1);
    vecs[4]  = mk(0, 0, 0, 5'd0,  0, 1, 5'd29, 1, 2'b01, 1, 4'd1, 1);
    vecs[5]  = mk(0, 0, 0, 5'd0,  0, 1, 5'd28, 1, 2'b01, 0, 4'd1, 1);
    vecs[6]  = mk(0, 1, 0, 5'd0,  0, 1, 5'd28, 1, 2'b00, 0, 4'd1, 1);
    vecs[7]  = mk(0, 0, 1, 5'd2,  0, 0, 5'd2,  1, 2'b00, 0, 4'd1, 1);
    vecs[8]  = mk(1, 0, 0, 5'd0,  0, 0, 5'd2,  1, 2'b01, 0, 4'd1, 1);
    vecs[9]  = mk(0, 0, 0, 5'd0,  0, 0, 5'd1,  1, 2'b01, 0, 4'd1, 1);
    vecs[10] = mk(0, 0, 0, 5'd0,  0, 0, 5'd0,  1, 2'b10, 0, 4'd1, 1);
    vecs[11] = mk(0, 0, 0, 5'd0,  0, 0, 5'd30, 1, 2'b01, 1, 4'd2, 1);
    vecs[12] = mk(0, 0, 0, 5'd0,  0, 0, 5'd29, 1, 2'b01, 0, 4'd2, 1);
    vecs[13] = mk(0, 0, 1, 5'd5,  0, 0, 5'd28, 1, 2'b01, 0, 4'd2, 1);
    vecs[14] = mk(1, 1, 0, 5'd0,  0, 0, 5'd28, 1, 2'b00, 0, 4'd2, 1);
    vecs[15] = mk(0, 1, 0, 5'd0,  0, 0, 5'd28, 1, 2'b00, 0, 4'd2, 0);
    vecs[16] = mk(1, 1, 0, 5'd0,  0, 0, 5'd28, 0, 2'b01, 0, 4'd0, 1);
    vecs[17] = mk(0, 0, 0, 5'd0,  0, 0, 5'd29, 0, 2'b01, 0, 4'd0, 1);
    vecs[18] = mk(0, 0, 0, 5'd0,  0, 0, 5'd30, 0, 2'b10, 0, 4'd0, 1);
    vecs[19] = mk(0, 0, 0, 5'd0,  0, 0, 5'd0,  0, 2'b01, 1, 4'd1, 1);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].ld, vecs[i].lv, vecs[i].dr, vecs[i].ar);
      check_all($sformatf("vec%0d", i), vecs[i].c, vecs[i].m, vecs[i].s, vecs[i].t,
                vecs[i].l, vecs[i].b);
    end

    // up wrap from 0: count reaches 30 after 30 RUN edges, then wraps with tc
    do_reset();
    drive(1, 0, 0, 5'd0, 0, 0);
    check_all("wrap_start", 5'd0, 0, 2'b01, 0, 4'd0, 1);
    for (int i = 0; i < 30; i++) drive(0, 0, 0, 5'd0, 0, 0);
    check_all("wrap_at_max", 5'd30, 0, 2'b10, 0, 4'd0, 1);
    drive(0, 0, 0, 5'd0, 0, 0);
    check_all("wrap_to_zero", 5'd0, 0, 2'b01, 1, 4'd1, 1);
    drive(0, 0, 0, 5'd0, 0, 0);
    check_all("wrap_tc_fall", 5'd1, 0, 2'b01, 0, 4'd1, 1);

    // asynchronous reset mid-run, then restart
    do_reset();
    drive(1, 0, 0, 5'd0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 5'd0, 0, 0);
    check("pre_reset_count", int'(count), 10);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_reset", 5'd0, 0, 2'b00, 0, 4'd0, 0);
    #1 rst_n = 1'b1;
    drive(1, 0, 0, 5'd0, 0, 0);
    check_all("restart_e", 5'd0, 0, 2'b01, 0, 4'd0, 1);
    drive(0, 0, 0, 5'd0, 0, 0);
    check("restart_1", int'(count), 1);
    drive(0, 0, 0, 5'd0, 0, 0);
    check("restart_2", int'(count), 2);

    // lap saturation over 20 laps
    do_reset();
    drive(1, 0, 0, 5'd0, 0, 0);
    for (int i = 0; i < 620; i++) drive(0, 0, 0, 5'd0, 0, 0);
    check_all("laps_sat", 5'd0, 0, 2'b01, 1, 4'd15, 1);
    for (int i = 0; i < 31; i++) drive(0, 0, 0, 5'd0, 0, 0);
    check("laps_held", int'(laps), 15);
    drive(0, 1, 0, 5'd0, 0, 0);
    drive(0, 1, 0, 5'd0, 0, 0);
    check_all("laps_idle_kept", 5'd0, 0, 2'b00, 0, 4'd15, 0);
    drive(1, 0, 0, 5'd0, 0, 0);
    check("laps_cleared", int'(laps), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
